uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched_pkg.sv | 16 +
 rtl/uart_tx_rr_arb.sv | 18 +
 rtl/uart_tx_sched.sv | 130 +++++++++++++
 tb/tb_uart_tx_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared constants for the UART transmit scheduler.
//   - 3-bit scheduler state encoding
//   - WAIT_HI timeout (cycles spent waiting for tx_busy to rise)
//   - byte width presented to the UART
package uart_tx_sched_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StGrant  = 3'd1;
  localparam logic [2:0] StStart  = 3'd2;
  localparam logic [2:0] StWaitHi = 3'd3;
  localparam logic [2:0] StWaitLo = 3'd4;

  localparam int unsigned WaitHiTimeout = 4;
  localparam int unsigned ByteW         = 8;

endpackage

// File: rtl/uart_tx_rr_arb.sv
// Two-input round-robin arbiter.
//   req0, req1   : request inputs
//   last_src     : index of the previously granted requester
//   grant_idx    : winning requester index (valid only with grant_valid)
//   grant_valid  : at least one request is present
module uart_tx_rr_arb (
  input  logic req0,
  input  logic req1,
  input  logic last_src,
  output logic grant_idx,
  output logic grant_valid
);

  assign grant_valid = req0 | req1;
  // On a tie the requester that did not win last time goes next.
  assign grant_idx   = (req0 && req1) ? ~last_src : req1;

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules words from two requesters onto a byte-serial UART transmitter.
//   clk, reset        : clock, asynchronous active-low reset
//   req0/req1         : word-valid from each requester (held until ack)
//   data0/data1       : N-bit word of each requester
//   ack0/ack1         : one-cycle capture acknowledge
//   tx_data, tx_start : byte and start pulse to the UART
//   tx_busy           : UART is shifting a frame
//   sched_busy        : scheduler not idle
//   last_src          : most recently granted requester
//   words_sent        : wrapping count of completed words
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] data0,
  input  logic [N-1:0] data1,
  output logic         ack0,
  output logic         ack1,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  input  logic         tx_busy,
  output logic         sched_busy,
  output logic         last_src,
  output logic [15:0]  words_sent
);

  localparam int unsigned NB = N / ByteW;

  logic [2:0]   state_q, state_d;
  logic [N-1:0] sreg_q, sreg_d;
  logic [1:0]   bcnt_q, bcnt_d;
  logic [1:0]   tmo_q, tmo_d;
  logic         last_src_q, last_src_d;
  logic [15:0]  words_sent_q, words_sent_d;

  logic grant_idx;
  logic grant_valid;

  uart_tx_rr_arb u_arb (
    .req0        (req0),
    .req1        (req1),
    .last_src    (last_src_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    bcnt_d       = bcnt_q;
    tmo_d        = tmo_q;
    last_src_d   = last_src_q;
    words_sent_d = words_sent_q;
    case (state_q)
      StIdle: begin
        if (req0 || req1) state_d = StGrant;
      end
      StGrant: begin
        if (grant_valid) begin
          sreg_d     = grant_idx ? data1 : data0;
          last_src_d = grant_idx;
          bcnt_d     = 2'(NB - 1);
          state_d    = StStart;
        end else begin
          state_d = StIdle;
        end
      end
      StStart: begin
        tmo_d   = '0;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        // Don't hang if the UART never reports busy.
        if (tx_busy || (tmo_q == 2'(WaitHiTimeout - 1))) begin
          state_d = StWaitLo;
        end else begin
          tmo_d = tmo_q + 2'd1;
        end
      end
      StWaitLo: begin
        if (!tx_busy) begin
          if (bcnt_q != '0) begin
            sreg_d  = sreg_q << ByteW;
            bcnt_d  = bcnt_q - 2'd1;
            state_d = StStart;
          end else begin
            words_sent_d = words_sent_q + 16'd1;
            state_d      = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      sreg_q       <= '0;
      bcnt_q       <= '0;
      tmo_q        <= '0;
      last_src_q   <= 1'b1;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      bcnt_q       <= bcnt_d;
      tmo_q        <= tmo_d;
      last_src_q   <= last_src_d;
      words_sent_q <= words_sent_d;
    end
  end

  // Outputs decode from registered state so reset clears them immediately.
  // The shift register only moves on entry to START, so its top byte holds
  // from one START to the next.
  assign ack0       = (state_q == StGrant) && grant_valid && !grant_idx;
  assign ack1       = (state_q == StGrant) && grant_valid && grant_idx;
  assign tx_start   = (state_q == StStart);
  assign tx_data    = sreg_q[N-1 -: ByteW];
  assign sched_busy = (state_q != StIdle);
  assign last_src   = last_src_q;
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched (N=16 main instance, N=32 second).
module tb_uart_tx_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0, req1;
  logic [15:0] data0, data1;
  logic        ack0, ack1, tx_start, tx_busy, sched_busy, last_src;
  logic [7:0]  tx_data;
  logic [15:0] words_sent;

  logic        req0_w, req1_w, ack0_w, ack1_w, tx_start_w, sched_busy_w, last_src_w;
  logic [31:0] data0_w, data1_w;
  logic [7:0]  tx_data_w;
  logic [15:0] words_sent_w;
  logic        tx_busy_w;

  int checks = 0;
  int passed = 0;

  uart_tx_sched #(.N(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .data0      (data0),
    .data1      (data1),
    .ack0       (ack0),
    .ack1       (ack1),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .sched_busy (sched_busy),
    .last_src   (last_src),
    .words_sent (words_sent)
  );

  uart_tx_sched #(.N(32)) dut_w (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0_w),
    .req1       (req1_w),
    .data0      (data0_w),
    .data1      (data1_w),
    .ack0       (ack0_w),
    .ack1       (ack1_w),
    .tx_data    (tx_data_w),
    .tx_start   (tx_start_w),
    .tx_busy    (tx_busy_w),
    .sched_busy (sched_busy_w),
    .last_src   (last_src_w),
    .words_sent (words_sent_w)
  );

  assign tx_busy_w = 1'b0;

  // UART model: busy for 10 cycles after each start when busy_mode is set.
  bit busy_mode = 1'b1;
  int busy_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) busy_cnt <= 0;
    else if (busy_mode && tx_start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  bit overlap_seen = 1'b0;
  int starts_w = 0;
  always @(posedge clk) begin
    if ((ack0 && ack1) || ((ack0 || ack1) && tx_start)) overlap_seen = 1'b1;
    if ((ack0_w && ack1_w) || ((ack0_w || ack1_w) && tx_start_w)) overlap_seen = 1'b1;
    if (tx_start_w) starts_w = starts_w + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (sched_busy && n < 200) begin @(negedge clk); n++; end
    check({name, " idle"}, 32'(sched_busy), 32'd0);
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (!(ack0 || ack1) && n < 100) begin @(negedge clk); n++; end
    check({name, " ack seen"}, 32'(ack0 | ack1), 32'd1);
  endtask

  // Returns the byte of the next tx_start pulse, then steps past it.
  task automatic wait_start(input string name, output logic [7:0] b);
    int n = 0;
    while (!tx_start && n < 100) begin @(negedge clk); n++; end
    check({name, " start seen"}, 32'(tx_start), 32'd1);
    b = tx_data;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    bit          r0;
    bit          r1;
    logic [15:0] d0;
    logic [15:0] d1;
    bit          bmode;
    bit          src;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0]  b;
    logic [15:0] exp_words;
    int          gap;
    int          s0;
    int          n;

    vecs[0] = '{1'b1, 1'b0, 16'h25DC, 16'h0000, 1'b1, 1'b0, 8'h25, 8'hDC};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'hBEEF, 1'b1, 1'b1, 8'hBE, 8'hEF};
    vecs[2] = '{1'b1, 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b0, 8'h12, 8'h34};
    vecs[3] = '{1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0, 1'b1, 8'h56, 8'h78};
    vecs[4] = '{1'b1, 1'b0, 16'h0FF0, 16'h0000, 1'b0, 1'b0, 8'h0F, 8'hF0};

    reset = 1'b0;
    req0 = 0; req1 = 0; data0 = '0; data1 = '0;
    req0_w = 0; req1_w = 0; data0_w = '0; data1_w = '0;
    @(negedge clk);
    check("rst sched_busy", 32'(sched_busy), 32'd0);
    check("rst last_src", 32'(last_src), 32'd1);
    check("rst words_sent", 32'(words_sent), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'd0);
    check("rst ack/start", {29'd0, ack1, ack0, tx_start}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Table: single words and tie-breaking.
    exp_words = 16'd0;
    for (int i = 0; i < 5; i++) begin
      wait_idle($sformatf("v%0d pre", i));
      busy_mode = vecs[i].bmode;
      data0 = vecs[i].d0; data1 = vecs[i].d1;
      req0 = vecs[i].r0; req1 = vecs[i].r1;
      @(negedge clk);
      check($sformatf("v%0d ack latency", i), {30'd0, ack1, ack0},
            vecs[i].src ? 32'd2 : 32'd1);
      @(negedge clk);
      req0 = 0; req1 = 0;
      check($sformatf("v%0d start latency", i), 32'(tx_start), 32'd1);
      check($sformatf("v%0d byte0", i), 32'(tx_data), 32'(vecs[i].b0));
      check($sformatf("v%0d last_src", i), 32'(last_src), 32'(vecs[i].src));
      @(negedge clk);
      wait_start($sformatf("v%0d b1", i), b);
      check($sformatf("v%0d byte1", i), 32'(b), 32'(vecs[i].b1));
      wait_idle($sformatf("v%0d post", i));
      exp_words = exp_words + 16'd1;
      check($sformatf("v%0d words_sent", i), 32'(words_sent), 32'(exp_words));
    end

    // Timeout: busy never rises, START then exactly 5 wait cycles.
    busy_mode = 1'b0;
    data0 = 16'h1122; req0 = 1;
    @(negedge clk);
    @(negedge clk);
    req0 = 0;
    check("tmo byte0", 32'(tx_data), 32'h11);
    gap = 0;
    do begin @(negedge clk); gap++; end while (!tx_start && gap < 20);
    check("tmo start gap", 32'(gap), 32'd6);
    check("tmo byte1", 32'(tx_data), 32'h22);
    wait_idle("tmo");
    check("tmo words_sent", 32'(words_sent), 32'd6);

    // Contention: both held high, grants alternate from requester 0.
    do_reset();
    data0 = 16'hAAAA; data1 = 16'h5555;
    req0 = 1; req1 = 1;
    for (int w = 0; w < 4; w++) begin
      wait_ack($sformatf("rr w%0d", w));
      check($sformatf("rr w%0d grant", w), 32'(ack1), 32'(w % 2));
      for (int k = 0; k < 2; k++) begin
        wait_start($sformatf("rr w%0d b%0d", w, k), b);
        if (w == 3) begin req0 = 0; req1 = 0; end
        check($sformatf("rr w%0d byte%0d", w, k), 32'(b), (w % 2) ? 32'h55 : 32'hAA);
      end
    end
    wait_idle("rr");
    check("rr words_sent", 32'(words_sent), 32'd4);

    // Reset during WAIT_LO of byte 0, then req1 alone.
    busy_mode = 1'b1;
    data0 = 16'h9876; req0 = 1;
    wait_ack("mid");
    @(negedge clk);
    req0 = 0;
    wait_start("mid b0", b);
    check("mid byte0", 32'(b), 32'h98);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid rst sched_busy", 32'(sched_busy), 32'd0);
    check("mid rst last_src", 32'(last_src), 32'd1);
    check("mid rst words_sent", 32'(words_sent), 32'd0);
    check("mid rst tx_data", 32'(tx_data), 32'd0);
    check("mid rst ack/start", {29'd0, ack1, ack0, tx_start}, 32'd0);
    data1 = 16'hC3A5; req1 = 1;
    @(negedge clk);
    reset = 1'b1;
    wait_ack("mid r1");
    check("mid r1 grant", {30'd0, ack1, ack0}, 32'd2);
    @(negedge clk);
    req1 = 0;
    wait_start("mid r1 b0", b);
    check("mid r1 byte0", 32'(b), 32'hC3);
    wait_start("mid r1 b1", b);
    check("mid r1 byte1", 32'(b), 32'hA5);
    wait_idle("mid r1");
    check("mid r1 words_sent", 32'(words_sent), 32'd1);

    // Wrap of words_sent.
    busy_mode = 1'b0;
    force dut.words_sent_q = 16'hFFFF;
    @(negedge clk);
    release dut.words_sent_q;
    @(negedge clk);
    check("wrap preload", 32'(words_sent), 32'h0000FFFF);
    data0 = 16'h0102; req0 = 1;
    wait_ack("wrap");
    @(negedge clk);
    req0 = 0;
    wait_idle("wrap");
    check("wrap words_sent", 32'(words_sent), 32'd0);

    // N=32: four bytes, MSB first.
    s0 = starts_w;
    data0_w = 32'h01234567; req0_w = 1;
    n = 0;
    while (!ack0_w && n < 100) begin @(negedge clk); n++; end
    check("w32 ack0", 32'(ack0_w), 32'd1);
    @(negedge clk);
    req0_w = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!tx_start_w && n < 100) begin @(negedge clk); n++; end
      check($sformatf("w32 byte%0d", k), 32'(tx_data_w), 32'(8'h01 + 8'(k * 8'h22)));
      @(negedge clk);
    end
    n = 0;
    while (sched_busy_w && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("w32 start count", 32'(starts_w - s0), 32'd4);
    check("w32 words_sent", 32'(words_sent_w), 32'd1);

    check("ack/start overlap", 32'(overlap_seen), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
